// File: rtl/polyclear_sched.sv
// polyclear_sched: round-robin owner of the shared polynomial-clear port.
// One requester at a time gets the coefficient memory port; the block walks
// mem_addr from 0 to cnt-1 writing zeros, then pulses done for that requester.
module polyclear_sched #(
    parameter int NREQ   = 3,
    parameter int AW     = 11,
    parameter int DW     = 13,
    parameter int MAXLEN = 757
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [AW-1:0]   len,
    input  logic            mem_ready,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_din,
    output logic [NREQ-1:0] done
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, CLEAR, DONE} state_t;

    state_t          state;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   g;
    logic [GW-1:0]   win;
    logic            any;
    int              idx;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   len_c;

    // Round-robin pick: first set req bit at or above ptr, wrapping around.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && req[idx]) begin
                any = 1'b1;
                win = GW'(idx);
            end
        end
    end

    // Oversized requests are clamped to the polynomial length.
    assign len_c = (int'(len) > MAXLEN) ? AW'(MAXLEN) : len;

    // Main FSM; grant and done are registered so they are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            g        <= '0;
            cnt      <= '0;
            mem_addr <= '0;
            grant    <= '0;
            done     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        g     <= win;
                        grant <= NREQ'(1) << win;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    cnt      <= len_c;
                    mem_addr <= '0;
                    if (len_c == '0) begin
                        done  <= grant;
                        state <= DONE;
                    end else begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    // A stalled cycle holds both address and state.
                    if (mem_ready) begin
                        if (mem_addr == cnt - AW'(1)) begin
                            done  <= grant;
                            state <= DONE;
                        end else begin
                            mem_addr <= mem_addr + AW'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= '0;
                    grant <= '0;
                    ptr   <= (int'(g) == NREQ - 1) ? '0 : g + GW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write strobe follows mem_ready directly so no accepted cycle is lost.
    assign mem_we  = (state == CLEAR) && mem_ready;
    assign busy    = (state != IDLE);
    assign mem_din = '0;

endmodule

// File: tb/tb_polyclear_sched.sv
// Directed bench for polyclear_sched: latency, backpressure, clamp, fairness,
// mid-clear reset and late request changes, with hand-computed expectations.
module tb_polyclear_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [10:0] len;
    logic        mem_ready;
    logic [2:0]  grant;
    logic        busy;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [12:0] mem_din;
    logic [2:0]  done;

    polyclear_sched #(.NREQ(3), .AW(11), .DW(13), .MAXLEN(757)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .len       (len),
        .mem_ready (mem_ready),
        .grant     (grant),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int c0 = 0;

    // monitor state
    int         wr_cnt, wr_idx, last_addr, addr_bad, din_bad;
    int         done_cnt, done_rel, stall_rel, stall_addr;
    logic [2:0] done_val, last_done, g1;
    logic [2:0] order_q[$];
    int         wrd_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // sample outputs mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            if (int'(mem_addr) != wr_idx) addr_bad++;
            if (mem_din != 13'd0) din_bad++;
            last_addr = int'(mem_addr);
            wr_idx++;
            wr_cnt++;
        end
        if (cyc - c0 == 1) g1 = grant;
        if (stall_rel >= 0 && cyc - c0 == stall_rel) stall_addr = int'(mem_addr);
        if (done != 3'b000) begin
            if (done_cnt == 0) done_rel = cyc - c0;
            done_cnt++;
            done_val = done;
            order_q.push_back(done);
            wrd_q.push_back(wr_idx);
            wr_idx = 0;
        end
        last_done = done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        wr_cnt = 0; wr_idx = 0; last_addr = -1; addr_bad = 0; din_bad = 0;
        done_cnt = 0; done_rel = -1; stall_rel = -1; stall_addr = -1;
        done_val = 3'b000; g1 = 3'b000;
        order_q.delete();
        wrd_q.delete();
    endtask

    // one clock; requesters drop their bit after its done, optional stall cycle
    task automatic tick();
        @(posedge clk);
        #1;
        req = req & ~last_done;
        mem_ready = !(stall_rel >= 0 && (cyc - c0) == stall_rel);
    endtask

    task automatic go(input logic [2:0] r, input int l);
        clr_mon();
        tick();
        c0 = cyc;
        req = r;
        len = 11'(l);
        mem_ready = 1'b1;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt < n; i++) tick();
        chk(tag, done_cnt, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = 3'b000; len = '0; mem_ready = 1'b1;
        last_done = 3'b000;
        clr_mon();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single request, len 4
        go(3'b001, 4);
        wait_done(1, 20, "t1_done_cnt");
        chk("t1_busy7", busy, 0);
        chk("t1_grant1", g1, 3'b001);
        chk("t1_writes", wr_cnt, 4);
        chk("t1_addr_seq", addr_bad, 0);
        chk("t1_last_addr", last_addr, 3);
        chk("t1_din", din_bad, 0);
        chk("t1_done_cyc", done_rel, 6);
        chk("t1_done_val", done_val, 3'b001);

        // backpressure in second CLEAR cycle
        go(3'b001, 3);
        stall_rel = 3;
        wait_done(1, 20, "t2_done_cnt");
        chk("t2_writes", wr_cnt, 3);
        chk("t2_addr_seq", addr_bad, 0);
        chk("t2_last_addr", last_addr, 2);
        chk("t2_stall_addr", stall_addr, 1);
        chk("t2_done_cyc", done_rel, 6);

        // zero length
        go(3'b001, 0);
        wait_done(1, 20, "t3_done_cnt");
        chk("t3_writes", wr_cnt, 0);
        chk("t3_done_cyc", done_rel, 2);

        // clamp
        go(3'b001, 2000);
        wait_done(1, 900, "t3c_done_cnt");
        chk("t3c_writes", wr_cnt, 757);
        chk("t3c_last_addr", last_addr, 756);
        chk("t3c_addr_seq", addr_bad, 0);
        chk("t3c_done_cyc", done_rel, 759);

        // fairness from ptr = 0
        do_reset();
        go(3'b111, 2);
        wait_done(3, 60, "t4_done_cnt");
        chk("t4_ord0", order_q[0], 3'b001);
        chk("t4_ord1", order_q[1], 3'b010);
        chk("t4_ord2", order_q[2], 3'b100);
        go(3'b101, 2);
        wait_done(2, 40, "t4b_done_cnt");
        chk("t4b_ord0", order_q[0], 3'b001);
        chk("t4b_ord1", order_q[1], 3'b100);

        // move ptr to 2, then reset mid-clear
        go(3'b010, 0);
        wait_done(1, 20, "t5_pre_done");
        go(3'b110, 10);
        for (int i = 0; i < 40 && wr_cnt < 5; i++) tick();
        chk("t5_wr5", wr_cnt, 5);
        chk("t5_grant_first", g1, 3'b100);
        rst = 1'b1;
        #1;
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_we", mem_we, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_no_done", done_cnt, 0);
        tick();
        tick();
        clr_mon();
        rst = 1'b0;
        c0 = cyc;
        wait_done(2, 60, "t5_done_cnt");
        chk("t5_g1_after", g1, 3'b010);
        chk("t5_ord0", order_q[0], 3'b010);
        chk("t5_ord1", order_q[1], 3'b100);
        chk("t5_wr_first", wrd_q[0], 10);
        chk("t5_addr_seq", addr_bad, 0);
        chk("t5_done_cyc", done_rel, 12);

        // late req change during clear
        go(3'b001, 5);
        for (int i = 0; i < 20 && wr_cnt < 2; i++) tick();
        req = 3'b100;
        wait_done(2, 40, "t6_done_cnt");
        chk("t6_ord0", order_q[0], 3'b001);
        chk("t6_ord1", order_q[1], 3'b100);
        chk("t6_wr_first", wrd_q[0], 5);
        chk("t6_done_cyc", done_rel, 7);
        chk("t6_addr_seq", addr_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/polyclear_sched.md
# polyclear_sched

Round-robin scheduler that shares the polynomial-clear datapath of the SNTRUP757 core between several requesters (key generation, encapsulation, decapsulation buffers). It grants one requester at a time and drives the address counter and write-enable of the shared coefficient memory port to write zeros to coefficients 0..len-1. It then returns a one-cycle done pulse to the granted requester.

## Interface
- NREQ, 3: number of requesters (2..8)
- AW, 11: coefficient address width
- DW, 13: coefficient data width (q = 4591)
- MAXLEN, 757: maximum coefficient count; larger requests are clamped
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester clear request, level; held until matching done
- len  in  AW  coefficient count for the winning requester, sampled in GRANT
- mem_ready  in  1  shared memory port accepts a write this cycle
- grant  out  NREQ  one-hot owner of the memory port (GRANT, CLEAR, DONE)
- busy  out  1  state != IDLE
- mem_we  out  1  write strobe = (state == CLEAR) & mem_ready (combinational on mem_ready)
- mem_addr  out  AW  coefficient address, registered
- mem_din  out  DW  constant 0
- done  out  NREQ  one-hot, one-cycle completion pulse

## Operation
- States: IDLE, GRANT, CLEAR, DONE (2-bit encoding).
- IDLE:
  - If any req bit is set, pick winner g by round-robin, searching from ptr upward with wrap.
  - Register g and go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - grant[g] = 1.
  - Latch cnt = min(len, MAXLEN) and clear mem_addr to 0.
  - If cnt == 0, go to DONE. Otherwise go to CLEAR.
- CLEAR:
  - Each cycle with mem_ready = 1: one write occurs at mem_addr.
  - If mem_addr == cnt-1, go to DONE. Otherwise mem_addr += 1.
  - Cycles with mem_ready = 0: no write; mem_addr and state hold.
- DONE:
  - done[g] = 1 and grant[g] = 1 for exactly one cycle.
  - ptr <= (g+1) mod NREQ.
  - Go to IDLE.
- Once granted, a clear always runs to completion.
  - Dropping req[g] mid-clear does not abort.
  - New or extra req bits are ignored until IDLE.
- A requester still holding req in the IDLE cycle after its done is treated as a new request. Requesters must drop req on done.
- Address arithmetic is unsigned, AW bits. mem_addr never exceeds MAXLEN-1, so there is no wrap.
- len is not sampled outside GRANT.

## Timing
- Reset values (asynchronous, on rst = 1):
  - state = IDLE, ptr = 0, g = 0, cnt = 0, mem_addr = 0.
  - grant = 0, done = 0, busy = 0, mem_we = 0.
- Reset asserted mid-clear: immediate return to IDLE. No done pulse is issued and the partial clear is abandoned. Requesters must re-request.
- Latency with mem_ready held 1, req first seen at cycle 0 (IDLE):
  - GRANT at cycle 1.
  - Writes at cycles 2..cnt+1.
  - done at cycle cnt+2.
  - IDLE at cycle cnt+3.
  - Next grant no earlier than cycle cnt+4.
- With cnt = 0: done at cycle 2; no mem_we.
- Each mem_ready = 0 cycle in CLEAR adds exactly one cycle of latency.
- grant is stable from GRANT through DONE and changes only on IDLE entry/exit.
- Simultaneous requests: exactly one grant. The loser keeps req high and is served in priority order from the updated ptr.

## Test plan
- Single request: req = 001, len = 4, mem_ready = 1 -> grant = 001 at cycle 1; mem_we with addr 0,1,2,3 at cycles 2..5, mem_din = 0; done = 001 at cycle 6; busy low at cycle 7.
- Backpressure: len = 3, mem_ready low during the second CLEAR cycle -> addr 1 held for one cycle; exactly 3 writes (addr 0,1,2); done one cycle later than the no-stall case.
- Zero/clamp: len = 0 -> no writes, done at cycle 2. len = 2000 -> exactly 757 writes, last addr 756, done at cycle 759.
- Fairness: req = 111 held, each bit dropped on its done, len = 2 -> grant order 001, 010, 100. Then re-assert req = 101 -> 001 granted, then 100.
- Reset mid-clear: len = 10, rst asserted after the 5th write -> grant, mem_we, busy and done go 0 immediately, with no done pulse. After release, req still high -> new clear restarts at addr 0 with ptr = 0.
- Late req change: during CLEAR for requester 0, deassert req[0] and assert req[2] -> clear completes all len writes, done = 001, then requester 2 is granted.
